// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, start bit, 8 data bits LSB first,
// odd parity, stop bit, then device ACK sampling. Lines are driven open-drain via OEs.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Odd parity bit: makes the total number of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  state_t           state_r;
  logic             clk_meta_r;
  logic             clk_sync_r;
  logic             clk_prev_r;
  logic             data_meta_r;
  logic             data_sync_r;
  logic [8:0]       shadow_r;
  logic [3:0]       bit_idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  logic             fe_s;
  logic             timeout_s;

  // Two-flop synchronizers plus edge-history flop; preset to the idle (high) bus level.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  assign fe_s      = clk_prev_r & ~clk_sync_r;
  assign timeout_s = (cnt_r == TIMEOUT_LAST);

  // Frame sequencer with registered bus enables and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_err      <= 1'b0;
      shadow_r    <= 9'd0;
      bit_idx_r   <= 4'd0;
      cnt_r       <= '0;
      err_r       <= 1'b0;
    end else begin
      done   <= 1'b0;
      tx_err <= 1'b0;
      case (state_r)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          cnt_r       <= '0;
          if (tx_start) begin
            shadow_r   <= {odd_parity(tx_data), tx_data};
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state_r    <= S_INHIBIT;
          end else begin
            busy <= 1'b0;
          end
        end
        S_INHIBIT: begin
          if (cnt_r == INHIBIT_LAST) begin
            ps2_data_oe <= 1'b1;
            cnt_r       <= '0;
            state_r     <= S_START;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_START: begin
          ps2_clk_oe <= 1'b0;
          bit_idx_r  <= 4'd0;
          cnt_r      <= '0;
          err_r      <= 1'b0;
          state_r    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (fe_s) begin
            cnt_r     <= '0;
            bit_idx_r <= bit_idx_r + 4'd1;
            if (bit_idx_r == 4'd9) begin
              ps2_data_oe <= 1'b0;
              state_r     <= S_ACK;
            end else begin
              ps2_data_oe <= ~shadow_r[bit_idx_r];
            end
          end else if (timeout_s) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            tx_err      <= 1'b1;
            busy        <= 1'b0;
            state_r     <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_ACK: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (fe_s) begin
            err_r   <= data_sync_r;
            cnt_r   <= '0;
            state_r <= S_WAIT_IDLE;
          end else if (timeout_s) begin
            done    <= 1'b1;
            tx_err  <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (clk_sync_r && data_sync_r) begin
            done    <= 1'b1;
            tx_err  <= err_r;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else if (fe_s) begin
            cnt_r <= '0;
          end else if (timeout_s) begin
            done    <= 1'b1;
            tx_err  <= 1'b1;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
